// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that shares one 8:1 select path among eight requesters.
// It registers a one-hot grant and a matching 3-bit binary select for the
// 3-to-8 decoder / 8x1 mux (sel_o == i enables output i).
//
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN
//   defined   -> a hold counter caps continuous ownership at MAX_HOLD cycles
//                when another requester is pending, pulsing revoke_o.
//   undefined -> a grant persists until its owner drops req; revoke_o is 0.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (1..15)
//   HCW       hold-counter width, 2**HCW > MAX_HOLD
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset
//   req_i     [0:7] level-sensitive request per requester
//   gnt_o     [0:7] registered one-hot grant, zero when idle
//   sel_o     [2:0] registered binary index of the grant (holds when idle)
//   busy_o    high whenever a grant is active
//   revoke_o  one-cycle pulse when the hold limit forced a handover
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HCW      = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [0:7] req_i,
  output logic [0:7] gnt_o,
  output logic [2:0] sel_o,
  output logic       busy_o,
  output logic       revoke_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q;
  logic [0:7] gnt_q;
  logic [2:0] sel_q;
  logic [2:0] ptr_q;
  logic       revoke_q;

  logic       ownerReq;
  logic       limitHit;
  logic [0:7] searchReq;
  logic       found;
  logic [2:0] pick;
  logic       newGrant;
  logic       goIdle;
  logic       doRevoke;

  function automatic logic [0:7] toOneHot(input logic [2:0] idx);
    toOneHot      = '0;
    toOneHot[idx] = 1'b1;
  endfunction

  assign ownerReq = req_i[sel_q];

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [HCW-1:0] hold_q;

  assign limitHit = (state_q == GRANT) && (hold_q >= HCW'(MAX_HOLD));

  // Hold counter: loads 1 on every new grant, counts while the owner keeps
  // its request, saturates at MAX_HOLD, and restarts at 1 when the limit is
  // reached but nobody else is waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q <= '0;
    end else if (newGrant) begin
      hold_q <= HCW'(1);
    end else if (goIdle) begin
      hold_q <= '0;
    end else if (state_q == GRANT && ownerReq) begin
      if (limitHit) begin
        hold_q <= HCW'(1);
      end else if (hold_q < HCW'(MAX_HOLD)) begin
        hold_q <= hold_q + HCW'(1);
      end
    end
  end
`else
  // Parameters only matter when the hold limit is built; this keeps the
  // limit permanently inactive while still referencing them.
  assign limitHit = 1'b0 && (MAX_HOLD > 0) && (HCW > 0);
`endif

  // When the limit forces a handover the current owner is masked out so the
  // search picks a different requester; otherwise the owner's own request is
  // either low (handover) or irrelevant (IDLE).
  assign searchReq = (limitHit && ownerReq) ? (req_i & ~gnt_q) : req_i;

  // First requesting index in search order ptr, ptr+1, ... ptr+7 (mod 8).
  always_comb begin
    logic [2:0] idx;
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && searchReq[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Decide whether this edge starts a new grant, ends the current one, or
  // hands over because of the hold limit.
  always_comb begin
    newGrant = 1'b0;
    goIdle   = 1'b0;
    doRevoke = 1'b0;
    case (state_q)
      IDLE: begin
        newGrant = found;
      end
      GRANT: begin
        if (!ownerReq) begin
          newGrant = found;
          goIdle   = !found;
        end else if (limitHit) begin
          newGrant = found;
          doRevoke = found;
        end
      end
      default: begin
        goIdle = 1'b1;
      end
    endcase
  end

  // Arbiter state machine; gnt and sel always move on the same edge, and the
  // pointer advances just past each newly granted index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      sel_q    <= '0;
      ptr_q    <= '0;
      revoke_q <= 1'b0;
    end else begin
      revoke_q <= doRevoke;
      if (newGrant) begin
        state_q <= GRANT;
        gnt_q   <= toOneHot(pick);
        sel_q   <= pick;
        ptr_q   <= pick + 3'd1;
      end else if (goIdle) begin
        state_q <= IDLE;
        gnt_q   <= '0;
      end
    end
  end

  assign gnt_o    = gnt_q;
  assign sel_o    = sel_q;
  assign busy_o   = |gnt_q;
  assign revoke_o = revoke_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model of the
// round-robin rules. Honours MUX_ARB_HOLD_LIMIT_EN the same way the design does.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:7] req;
  logic [0:7] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       revoke;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: owner index (-1 when idle), pointer, hold count.
  int mOwner = -1;
  int mPtr   = 0;
  int mHold  = 0;
  int mSel   = 0;
  bit mRevoke = 1'b0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HCW(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .sel_o    (sel),
    .busy_o   (busy),
    .revoke_o (revoke)
  );

  function automatic logic [0:7] oneHot(input int i);
    logic [0:7] e;
    e = '0;
    if (i >= 0) e[i] = 1'b1;
    return e;
  endfunction

  function automatic int firstReq(input logic [0:7] r, input int start, input int skip);
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (start + k) % 8;
      if (idx != skip && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic modelGrant(input int p);
    mOwner = p;
    mSel   = p;
    mPtr   = (p + 1) % 8;
    mHold  = 1;
  endtask

  task automatic modelStep();
    int p;
    if (rst) begin
      mOwner = -1; mPtr = 0; mHold = 0; mSel = 0; mRevoke = 1'b0;
    end else begin
      mRevoke = 1'b0;
      if (mOwner < 0) begin
        p = firstReq(req, mPtr, -1);
        if (p >= 0) modelGrant(p);
      end else if (!req[mOwner]) begin
        p = firstReq(req, mPtr, -1);
        if (p >= 0) modelGrant(p);
        else begin
          mOwner = -1;
          mHold  = 0;
        end
      end else begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
        if (mHold >= MAX_HOLD) begin
          p = firstReq(req, mPtr, mOwner);
          if (p >= 0) begin
            modelGrant(p);
            mRevoke = 1'b1;
          end else begin
            mHold = 1;
          end
        end else begin
          mHold = mHold + 1;
        end
`else
        mHold = mHold + 1;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    repeat (3) begin
      tick();
      checks++;
      if ({gnt, sel, busy, revoke} !== 13'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold: gnt=%b sel=%0d busy=%b revoke=%b, required all zero",
                 gnt, sel, busy, revoke);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== oneHot(0) || sel !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: gnt=%b sel=%0d busy=%b, required gnt=%b sel=0 busy=1",
               gnt, sel, busy, oneHot(0));
    end
    req = '0;
    tick();
  endtask

  task automatic test_single();
    req = '0;
    tick();
    req[5] = 1'b1;
    tick();
    checks++;
    if (gnt !== oneHot(5) || sel !== 3'd5) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt=%b sel=%0d, required gnt=%b sel=5", gnt, sel, oneHot(5));
    end
    repeat (3) begin
      tick();
      checks++;
      if (gnt !== oneHot(5) || sel !== 3'd5 || revoke !== 1'b0) begin
        errors++;
        $display("[TB] FAIL single_hold: gnt=%b sel=%0d revoke=%b, required gnt=%b sel=5 revoke=0",
                 gnt, sel, revoke, oneHot(5));
      end
    end
    req[5] = 1'b0;
    tick();
    checks++;
    if (gnt !== 8'd0 || busy !== 1'b0 || sel !== 3'd5) begin
      errors++;
      $display("[TB] FAIL single_release: gnt=%b busy=%b sel=%0d, required gnt=0 busy=0 sel=5",
               gnt, busy, sel);
    end
  endtask

  task automatic test_rotation();
    logic [0:7] r;
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    req = 8'hFF;
    tick();
    checks++;
    if (gnt !== oneHot(0) || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL rotation_start: gnt=%b sel=%0d, required sel=0", gnt, sel);
    end
    for (int k = 1; k <= 8; k++) begin
      r = 8'hFF;
      r[(k - 1) % 8] = 1'b0;
      req = r;
      tick();
      checks++;
      if (gnt !== oneHot(k % 8) || sel !== 3'((k % 8)) || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rotation_step%0d: gnt=%b sel=%0d busy=%b, required sel=%0d busy=1",
                 k, gnt, sel, busy, k % 8);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_wrap();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    req = oneHot(6);
    tick();
    checks++;
    if (sel !== 3'd6) begin
      errors++;
      $display("[TB] FAIL wrap_serve6: sel=%0d, required 6", sel);
    end
    req = oneHot(7) | oneHot(0);
    tick();
    checks++;
    if (gnt !== oneHot(7) || sel !== 3'd7) begin
      errors++;
      $display("[TB] FAIL wrap_grant7: gnt=%b sel=%0d, required sel=7", gnt, sel);
    end
    req = oneHot(0);
    tick();
    checks++;
    if (gnt !== oneHot(0) || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL wrap_grant0: gnt=%b sel=%0d, required sel=0", gnt, sel);
    end
    req = '0;
    tick();
  endtask

  task automatic test_hold_limit();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    req = oneHot(2) | oneHot(3);
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      checks++;
      if (gnt !== oneHot(2) || sel !== 3'd2 || revoke !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_owner2_cycle%0d: gnt=%b sel=%0d revoke=%b, required sel=2 revoke=0",
                 c, gnt, sel, revoke);
      end
    end
    tick();
`ifdef MUX_ARB_HOLD_LIMIT_EN
    checks++;
    if (gnt !== oneHot(3) || sel !== 3'd3 || revoke !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_revoke: gnt=%b sel=%0d revoke=%b, required sel=3 revoke=1",
               gnt, sel, revoke);
    end
    tick();
    checks++;
    if (gnt !== oneHot(3) || revoke !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_revoke_pulse: gnt=%b revoke=%b, required gnt=%b revoke=0",
               gnt, revoke, oneHot(3));
    end
`else
    checks++;
    if (gnt !== oneHot(2) || revoke !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_persist: gnt=%b revoke=%b, required gnt=%b revoke=0",
               gnt, revoke, oneHot(2));
    end
    repeat (4) tick();
    checks++;
    if (gnt !== oneHot(2) || revoke !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_persist_late: gnt=%b revoke=%b, required gnt=%b revoke=0",
               gnt, revoke, oneHot(2));
    end
`endif
    req = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    req = oneHot(4);
    tick();
    checks++;
    if (gnt !== oneHot(4) || sel !== 3'd4) begin
      errors++;
      $display("[TB] FAIL midreset_grant4: gnt=%b sel=%0d, required sel=4", gnt, sel);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({gnt, sel, busy, revoke} !== 13'd0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: gnt=%b sel=%0d busy=%b revoke=%b, required all zero",
               gnt, sel, busy, revoke);
    end
    rst = 1'b0;
    req = 8'hFF;
    tick();
    checks++;
    if (gnt !== oneHot(0) || sel !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midreset_restart: gnt=%b sel=%0d, required sel=0", gnt, sel);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      req = req ^ 8'($urandom & $urandom & $urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (gnt !== oneHot(mOwner) || sel !== 3'(mSel) || busy !== (mOwner >= 0) ||
          revoke !== mRevoke) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: gnt=%b sel=%0d busy=%b revoke=%b, required gnt=%b sel=%0d busy=%b revoke=%b",
                 n, gnt, sel, busy, revoke, oneHot(mOwner), mSel, (mOwner >= 0), mRevoke);
      end
    end
    rst = 1'b0;
    req = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_hold_limit();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 8:1 select path among eight requesters. It registers one-hot grants and drives the 3-bit binary select that feeds the 3-to-8 decoder and 8x1 mux. The select encoding matches the decoder: `sel == i` enables output `o[i]`. A grant is held while its requester keeps `req` high; an optional hold limit stops any single requester from starving the others.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per requester when the hold limit is compiled in. Legal range 1..15.
- `HCW`, default 4: hold-counter width. Must satisfy `2**HCW > MAX_HOLD`.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — reset, synchronous, active-high.
- `req`  in  [0:7]  — request per requester; level-sensitive; held high until service is complete.
- `gnt`  out  [0:7]  — registered one-hot grant; all-zero when idle.
- `sel`  out  [2:0]  — registered binary index of the current grant; drives the mux/decoder select.
- `busy`  out  1  — high whenever any `gnt` bit is high.
- `revoke`  out  1  — one-cycle pulse when a grant is removed by the hold limit rather than by `req` dropping.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: exactly one `gnt[i]` high, and `sel == i`.
- Priority pointer `ptr[2:0]`:
  - Search order is `ptr`, `ptr+1`, … `ptr+7`, all mod 8.
  - After granting `i`, `ptr` becomes `(i+1) mod 8`.
- IDLE -> GRANT:
  - At an edge where `req != 0`, grant the first requesting index in search order.
- GRANT, owner `i` with `req[i] == 1` and the limit not reached: keep the grant and increment the hold counter.
- GRANT, owner `req[i] == 0` at an edge, others pending: switch directly to the next requester in search order. There is no idle bubble.
- GRANT, owner `req[i] == 0` at an edge, none pending: go to IDLE, `gnt = 0`, `sel` holds its last value.
- Hold limit (only with the macro), after `MAX_HOLD` cycles of continuous grant to `i`:
  - If another requester is pending: grant the next one in search order, which excludes `i`, and pulse `revoke`.
  - If no other requester is pending: keep granting `i`, reset the counter to 1, and do not pulse `revoke`.
- The hold counter loads 1 on every new grant and saturates at `MAX_HOLD`.
- Arithmetic:
  - `ptr` and the search index wrap mod 8.
  - Index 7 is followed by index 0.
- Reset values (`rst` high at an edge):
  - `gnt = 0`, `sel = 3'b000`, `busy = 0`, `revoke = 0`.
  - `ptr = 0`, hold counter = 0, state IDLE.
  - Reset overrides every request, including in the middle of a grant.

## Timing
- Latency: `req` sampled at edge N gives `gnt`/`sel` valid after edge N (one cycle).
- A requester must keep `req` high until it observes `gnt`. Dropping `req` before the grant is legal: no grant is issued for it if it is low at the deciding edge.
- Handover: owner drops `req` in cycle N, the next owner's `gnt` is high after edge N+1's… more precisely, `gnt` changes at the first edge where `req[i]` is sampled low.
- `sel` and `gnt` always change on the same edge, so `sel` is never stale while `busy` is high.
- `revoke` is high for exactly the cycle in which the new owner's `gnt` first appears.
- Simultaneous requests: resolved purely by `ptr`; no fixed priority otherwise.

## Configuration
- `MUX_ARB_HOLD_LIMIT_EN` defined:
  - Hold counter and `MAX_HOLD` enforcement are built.
  - `revoke` behaves as described above.
- Not defined:
  - No hold counter; a grant persists until the owner drops `req`.
  - `revoke` is tied to 0.
  - `MAX_HOLD`/`HCW` are accepted but unused.

## Test plan
- Reset: `rst=1` with `req=8'hFF` for 3 cycles, then release. `gnt`, `sel`, `busy` and `revoke` stay 0 during reset. First grant after release is `gnt[0]`, `sel=0`.
- Single requester: `req[5]` raised at edge 10. `gnt[5]=1` and `sel=5` after edge 10. Drop `req[5]` at edge 14; `gnt=0`, `busy=0` after edge 14.
- Rotation: `req=8'hFF` held, each owner drops `req` one cycle after its grant. Grant order is 0,1,2,…,7,0 with no idle cycles.
- Wrap: `ptr=7` (after serving 6), `req[7]` and `req[0]` high. Grant 7 first; on its release grant 0.
- Hold limit (macro on, `MAX_HOLD=8`): `req[2]` and `req[3]` held high. `gnt[2]` for exactly 8 cycles, then `gnt[3]` with `revoke=1` for 1 cycle.
  - Same stimulus with the macro off: `gnt[2]` persists indefinitely.
- Mid-grant reset: `gnt[4]` active with `req[4]` still high, `rst` asserted for one edge. All outputs become 0. After release, grant restarts from `ptr=0` search order.
